// File: rtl/md_sched.sv
// md_sched: multiply/divide scheduler beside EX. It runs each MD operation
// through a fixed-latency busy window and owns the architectural HI/LO.
// The result is computed when the operation is accepted, parked in a
// pending register, and committed to HI/LO on the edge that ends the window.
module md_sched #(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        md_use_D,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  // The counter is loaded with latency-1, so the final RUN cycle sees cnt == 0.
  localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);
  localparam logic [3:0] DIV_CNT = 4'(DIV_LAT - 1);

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic [31:0] p_hi, p_lo;
  logic        p_wr;

  logic        load, commit, mt_hi, mt_lo;

  logic [63:0] prod_s, prod_u;
  logic [31:0] abs_a, abs_b, div_b, sdiv_b;
  logic [31:0] uq, ur, mq, mr, sq, sr;
  logic [31:0] r_hi, r_lo;
  logic        r_wr;

  // Result datapath: products and quotients of the operands currently in EX.
  // Divisors of zero are replaced by one so the dividers stay well defined;
  // the result is then discarded through r_wr.
  always_comb begin
    prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    prod_u = {32'd0, a} * {32'd0, b};
    abs_a  = a[31] ? (32'd0 - a) : a;
    abs_b  = b[31] ? (32'd0 - b) : b;
    div_b  = (b == 32'd0) ? 32'd1 : b;
    sdiv_b = (abs_b == 32'd0) ? 32'd1 : abs_b;
    uq     = a / div_b;
    ur     = a % div_b;
    mq     = abs_a / sdiv_b;
    mr     = abs_a % sdiv_b;
    // Truncating signed division: quotient negative when signs differ,
    // remainder takes the sign of the dividend.
    sq     = (a[31] ^ b[31]) ? (32'd0 - mq) : mq;
    sr     = a[31] ? (32'd0 - mr) : mr;
    r_hi   = 32'd0;
    r_lo   = 32'd0;
    r_wr   = 1'b1;
    case (op[1:0])
      2'd0: begin r_hi = prod_s[63:32]; r_lo = prod_s[31:0]; end
      2'd1: begin r_hi = prod_u[63:32]; r_lo = prod_u[31:0]; end
      2'd2: begin r_hi = sr; r_lo = sq; r_wr = (b != 32'd0); end
      default: begin r_hi = ur; r_lo = uq; r_wr = (b != 32'd0); end
    endcase
  end

  // Next-state and control: accept only in IDLE, count down in RUN.
  // A start seen in RUN is deliberately ignored.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    load     = 1'b0;
    commit   = 1'b0;
    mt_hi    = 1'b0;
    mt_lo    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          case (op)
            3'd0, 3'd1: begin load = 1'b1; cnt_nx = MUL_CNT; state_nx = RUN; end
            3'd2, 3'd3: begin load = 1'b1; cnt_nx = DIV_CNT; state_nx = RUN; end
            3'd4:       mt_hi = 1'b1;
            3'd5:       mt_lo = 1'b1;
            default:    ;
          endcase
        end
      end
      RUN: begin
        if (cnt != 4'd0) begin
          cnt_nx = cnt - 4'd1;
        end else begin
          commit   = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register and down-counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Pending result capture and HI/LO updates (commit or mthi/mtlo).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_hi <= 32'd0;
      p_lo <= 32'd0;
      p_wr <= 1'b0;
      hi   <= 32'd0;
      lo   <= 32'd0;
    end else begin
      if (load) begin
        p_hi <= r_hi;
        p_lo <= r_lo;
        p_wr <= r_wr;
      end
      if (commit && p_wr) begin
        hi <= p_hi;
        lo <= p_lo;
      end
      if (mt_hi) hi <= a;
      if (mt_lo) lo <= a;
    end
  end

  assign busy      = (state == RUN);
  // Hold an MD-class instruction in ID until HI/LO are final.
  assign stall_req = md_use_D & (busy | (start & (op <= 3'd3)));

endmodule
